// File: rtl/frame_tx110.sv
// frame_tx110: serial "110"-preamble frame transmitter (preamble 1,1,0, payload MSB first, guard 0).
// Define FRAME_TX110_PARITY_EN to insert an even-parity bit between the payload and the guard bit.
module frame_tx110 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              bit_en,
  output logic              tx_ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
`ifdef FRAME_TX110_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sout_q, sout_d;
  logic              done_q, done_d;
`ifdef FRAME_TX110_PARITY_EN
  logic              par_q, par_d;
`endif
  // cnt_q indexes the preamble bit in PRE and counts payload bits already presented in DATA
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
`ifdef FRAME_TX110_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (tx_valid) begin
        state_d = PRE;
        shift_d = tx_data;
        cnt_d   = '0;
        sout_d  = 1'b1;
`ifdef FRAME_TX110_PARITY_EN
        par_d   = ^tx_data;
`endif
      end
      PRE: if (bit_en) begin
        if (cnt_q == CW'(2)) begin
          state_d = DATA;
          sout_d  = shift_q[DATA_W-1];
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = CW'(1);
        end else begin
          sout_d  = (cnt_q == '0);
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DATA: if (bit_en) begin
        if (cnt_q == CW'(DATA_W)) begin
          cnt_d   = '0;
`ifdef FRAME_TX110_PARITY_EN
          state_d = PAR;
          sout_d  = par_q;
`else
          state_d = STOP;
          sout_d  = 1'b0;
`endif
        end else begin
          sout_d  = shift_q[DATA_W-1];
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end
      end
`ifdef FRAME_TX110_PARITY_EN
      PAR: if (bit_en) begin
        state_d = STOP;
        sout_d  = 1'b0;
      end
`endif
      STOP: if (bit_en) begin
        state_d = IDLE;
        sout_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        sout_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FRAME_TX110_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
`ifdef FRAME_TX110_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign sout     = sout_q;
  assign done     = done_q;
endmodule

// File: tb/tb_frame_tx110.sv
// tb_frame_tx110: random and directed stimulus checked against a frame-level reference model.
module tb_frame_tx110;
  localparam int W = 8;
`ifdef FRAME_TX110_PARITY_EN
  localparam int LEN = W + 5;
`else
  localparam int LEN = W + 4;
`endif
  logic clk = 1'b0;
  logic reset, tx_valid, bit_en, tx_ready, sout, busy, done;
  logic [W-1:0] tx_data;
  always #5 clk = ~clk;
  frame_tx110 #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .bit_en(bit_en), .tx_ready(tx_ready), .sout(sout), .busy(busy), .done(done)
  );
  int n_vec, n_bad, cyc;
  bit m_busy, m_done, prev_busy;
  int m_k;
  bit m_frame[$];
  int dut_acc[$], dut_done[$];
  int busy_cnt, done_cnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  // Frame-level model: the whole frame is built as a bit list at accept, then indexed by bit time
  task automatic model_step();
    bit nd = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      return;
    end
    if (!m_busy) begin
      if (tx_valid) begin
        m_frame.delete();
        m_frame.push_back(1'b1);
        m_frame.push_back(1'b1);
        m_frame.push_back(1'b0);
        for (int i = W - 1; i >= 0; i--) m_frame.push_back(tx_data[i]);
`ifdef FRAME_TX110_PARITY_EN
        m_frame.push_back(^tx_data);
`endif
        m_frame.push_back(1'b0);
        m_busy = 1'b1;
        m_k = 0;
      end
    end else if (bit_en) begin
      m_k++;
      if (m_k == m_frame.size()) begin
        m_busy = 1'b0;
        nd = 1'b1;
      end
    end
    m_done = nd;
  endtask
  task automatic check_outs();
    chk("sout", 32'(sout), 32'(m_busy ? m_frame[m_k] : 1'b0));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("tx_ready", 32'(tx_ready), 32'(!m_busy));
    if (busy === 1'b1 && !prev_busy) dut_acc.push_back(cyc);
    if (done === 1'b1) begin
      dut_done.push_back(cyc);
      done_cnt++;
    end
    if (busy === 1'b1) busy_cnt++;
    prev_busy = (busy === 1'b1);
  endtask
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic e);
    tx_valid = v;
    tx_data  = d;
    bit_en   = e;
    @(posedge clk);
    cyc++;
    model_step();
    #1 check_outs();
  endtask
  initial begin
    int got;
    n_vec = 0; n_bad = 0; cyc = 0;
    m_busy = 0; m_done = 0; prev_busy = 0; busy_cnt = 0; done_cnt = 0;
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; bit_en = 1'b0;
    #2 check_outs();
    #20 reset = 1'b0;
    repeat (5) cycle(1'b0, '0, 1'b0);
    // full-rate frame of 0xA5
    done_cnt = 0;
    cycle(1'b1, 8'hA5, 1'b1);
    repeat (LEN + 3) cycle(1'b0, W'($urandom), 1'b1);
    chk("a5_done_pulses", 32'(done_cnt), 32'd1);
    // one bit every 4 cycles, with an ignored 0xFF mid-frame
    busy_cnt = 0;
    cycle(1'b1, 8'h81, 1'b0);
    for (int j = 1; j < 4 * LEN + 8; j++) cycle(j >= 10 && j < 20, 8'hFF, j % 4 == 0);
    chk("slow_span", 32'(busy_cnt), 32'(4 * LEN));
    // back-to-back: second word accepted at the end of the done cycle
    dut_acc.delete();
    dut_done.delete();
    got = 0;
    for (int j = 0; j < 100 && got < 2; j++) begin
      cycle(1'b1, got == 0 ? 8'h3C : 8'hC3, 1'b1);
      got = dut_acc.size();
    end
    chk("b2b_accepts", 32'(got), 32'd2);
    if (got == 2 && dut_done.size() > 0) chk("b2b_gap", 32'(dut_acc[1] - dut_done[0]), 32'd1);
    repeat (LEN + 3) cycle(1'b0, '0, 1'b1);
    // reset aborting a frame around edge t6
    done_cnt = 0;
    cycle(1'b1, 8'h96, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b1);
    reset = 1'b1;
    #1 model_step();
    check_outs();
    repeat (2) cycle(1'b0, '0, 1'b1);
    reset = 1'b0;
    repeat (3) cycle(1'b0, '0, 1'b1);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    cycle(1'b1, 8'h55, 1'b1);
    repeat (LEN + 3) cycle(1'b0, '0, 1'b1);
    chk("post_abort_done", 32'(done_cnt), 32'd1);
    // random traffic
    repeat (600) cycle($urandom_range(2) == 0, W'($urandom), $urandom_range(3) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
